flag_condition_unit: RTL
========================

# flag_condition_unit

Architectural status-flag register and condition evaluator that sits downstream of the ALU flag generators (N, Z, C, V). It latches flag updates from flag-setting instructions, evaluates 4-bit condition codes for conditional instructions with same-cycle forwarding, and tracks signed-overflow events. Tracking uses a saturating counter, a sticky bit, and a req/ack trap handshake toward the control unit.

## Interface
- CNT_W, 8, width of the saturating overflow-event counter (≥2)
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- flags_valid_i  in  1  ALU result valid this cycle
- flags_we_i  in  1  instruction updates flags (S bit); ignored unless flags_valid_i=1
- n_i, z_i, c_i, v_i  in  1 each  flags from the ALU flag generators
- cond_valid_i  in  1  evaluation request this cycle
- cond_i  in  4  condition code
- cond_done_o  out  1  cond_pass_o valid this cycle
- cond_pass_o  out  1  condition result
- flags_o  out  4  architectural flags {N,Z,C,V}
- trap_en_i  in  1  overflow trap enable
- ovf_trap_req_o  out  1  overflow trap request
- ovf_trap_ack_i  in  1  trap acknowledge
- ovf_sticky_o  out  1  sticky overflow indicator
- ovf_count_o  out  CNT_W  saturating overflow-event count
- clr_sticky_i  in  1  clears sticky bit and counter

## Operation
- Update event: upd = flags_valid_i & flags_we_i. On upd, the flags register loads {n_i,z_i,c_i,v_i}. Otherwise it holds.
- Effective flags: eff = upd ? incoming flags : flags register. This is the forwarding path.
- Condition evaluation uses eff:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: reserved, always 0
- Overflow event: ovf = upd & v_i. This is independent of trap_en_i.
- Counter:
  - On ovf, increments by 1, saturating at 2^CNT_W−1 (no wrap).
  - clr_sticky_i clears it to 0.
  - clr_sticky_i and ovf in the same cycle give 1.
- Sticky: set on ovf, cleared by clr_sticky_i. Set wins over a simultaneous clear.
- Trap FSM, two states:
  - IDLE: ovf & trap_en_i → REQ.
  - REQ: ovf_trap_req_o=1. Leaves only when ovf_trap_ack_i=1.
    - ack without a new trap-enabled ovf → IDLE.
    - ack with a new trap-enabled ovf in the same cycle → stays REQ (new request).
    - Trap-enabled ovf without ack is absorbed; it is not queued but is counted.
  - Deasserting trap_en_i while in REQ does not withdraw the request.
  - ack while in IDLE is ignored.

## Timing
- Reset values (asynchronous on rst_ni=0):
  - flags_o=4'b0000, cond_done_o=0, cond_pass_o=0
  - ovf_trap_req_o=0, FSM=IDLE
  - ovf_sticky_o=0, ovf_count_o=0
- All outputs are registered, with no combinational input-to-output path.
- flags_o reflects an update one cycle after upd.
- cond_done_o/cond_pass_o appear one cycle after cond_valid_i.
  - cond_done_o is high for exactly one cycle per request.
  - Back-to-back requests give back-to-back results.
  - cond_pass_o holds its last value when cond_done_o=0.
- Forwarding: cond_valid_i in the same cycle as upd evaluates the new flags, not the old.
- ovf_trap_req_o rises one cycle after a trap-enabled ovf. It falls one cycle after ack is sampled, unless it is re-armed.
- Counter and sticky update one cycle after ovf/clr_sticky_i.
- Reset asserted mid-handshake drops ovf_trap_req_o immediately. No request is pending after release.

## Test plan
- Reset:
  - Stimulus: rst_ni low mid-operation, with REQ pending, count=5, sticky=1, flags=4'b1111.
  - Required response: all outputs zero immediately; after release, ovf_trap_req_o stays 0 with no stimulus.
- Forwarding:
  - Stimulus: flags register=Z=1; same cycle upd with {0,0,0,0} and cond_valid_i with cond_i=0 (EQ).
  - Required response: next cycle cond_done_o=1, cond_pass_o=0, flags_o=0000.
- Exhaustive conditions:
  - Stimulus: all 16 NZCV patterns × 16 cond_i codes.
  - Required response: cond_pass_o matches the condition list above; code F always 0, code E always 1.
- Trap handshake:
  - Stimulus: trap_en_i=1, ovf at cycle t; hold ack low 3 cycles; a second ovf at t+2; ack at t+4.
  - Required response: req high t+1..t+4, low at t+5; count=2.
  - Stimulus (repeat): ovf coincident with ack.
  - Required response: req stays high.
- Saturation, CNT_W=2:
  - Stimulus: 5 ovf events.
  - Required response: count 1,2,3,3,3.
  - Stimulus: then clr_sticky_i with ovf in the same cycle.
  - Required response: count=1, sticky=1.
- Gating:
  - Stimulus: flags_we_i=1 with flags_valid_i=0 and v_i=1.
  - Required response: flags_o unchanged, count unchanged, no request.
  - Stimulus: ovf with trap_en_i=0.
  - Required response: count increments, sticky set, no request.

Source files
------------

// File: rtl/flag_condition_unit.sv
// Architectural NZCV flag register with forwarded condition evaluation,
// plus overflow-event tracking (saturating counter, sticky bit, trap req/ack).
module flag_condition_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flags_valid_i,
  input  logic             flags_we_i,
  input  logic             n_i,
  input  logic             z_i,
  input  logic             c_i,
  input  logic             v_i,
  input  logic             cond_valid_i,
  input  logic [3:0]       cond_i,
  output logic             cond_done_o,
  output logic             cond_pass_o,
  output logic [3:0]       flags_o,
  input  logic             trap_en_i,
  output logic             ovf_trap_req_o,
  input  logic             ovf_trap_ack_i,
  output logic             ovf_sticky_o,
  output logic [CNT_W-1:0] ovf_count_o,
  input  logic             clr_sticky_i
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             upd;
  logic             ovf;
  logic             trap_ovf;
  logic [3:0]       in_flags;
  logic [3:0]       eff;
  logic             eff_n, eff_z, eff_c, eff_v;
  logic [15:0]      cond_vec;
  logic             pass_next;

  logic [3:0]       flags_reg;
  logic             cond_done_reg;
  logic             cond_pass_reg;
  logic             sticky_reg;
  logic             sticky_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [0:0]       state_reg;
  logic [0:0]       state_next;

  assign upd      = flags_valid_i & flags_we_i;
  assign in_flags = {n_i, z_i, c_i, v_i};
  assign ovf      = upd & v_i;
  assign trap_ovf = ovf & trap_en_i;

  // Forward the incoming flags so a same-cycle evaluation sees the update.
  assign eff = upd ? in_flags : flags_reg;
  assign {eff_n, eff_z, eff_c, eff_v} = eff;

  always_comb begin
    cond_vec      = 16'h0000;
    cond_vec[0]   = eff_z;
    cond_vec[1]   = ~eff_z;
    cond_vec[2]   = eff_c;
    cond_vec[3]   = ~eff_c;
    cond_vec[4]   = eff_n;
    cond_vec[5]   = ~eff_n;
    cond_vec[6]   = eff_v;
    cond_vec[7]   = ~eff_v;
    cond_vec[8]   = eff_c & ~eff_z;
    cond_vec[9]   = ~eff_c | eff_z;
    cond_vec[10]  = (eff_n == eff_v);
    cond_vec[11]  = (eff_n != eff_v);
    cond_vec[12]  = ~eff_z & (eff_n == eff_v);
    cond_vec[13]  = eff_z | (eff_n != eff_v);
    cond_vec[14]  = 1'b1;
    cond_vec[15]  = 1'b0;
  end

  assign pass_next = cond_vec[cond_i];

  always_comb begin
    count_next = count_reg;
    if (clr_sticky_i) begin
      count_next = ovf ? CNT_ONE : '0;
    end else if (ovf && (count_reg != CNT_MAX)) begin
      count_next = count_reg + CNT_ONE;
    end
  end

  // Set wins over a simultaneous clear.
  assign sticky_next = ovf | (sticky_reg & ~clr_sticky_i);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (trap_ovf) state_next = ST_REQ;
      ST_REQ:  if (ovf_trap_ack_i) state_next = trap_ovf ? ST_REQ : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_reg     <= 4'b0000;
      cond_done_reg <= 1'b0;
      cond_pass_reg <= 1'b0;
      sticky_reg    <= 1'b0;
      count_reg     <= '0;
      state_reg     <= ST_IDLE;
    end else begin
      if (upd) flags_reg <= in_flags;
      cond_done_reg <= cond_valid_i;
      if (cond_valid_i) cond_pass_reg <= pass_next;
      sticky_reg    <= sticky_next;
      count_reg     <= count_next;
      state_reg     <= state_next;
    end
  end

  assign flags_o        = flags_reg;
  assign cond_done_o    = cond_done_reg;
  assign cond_pass_o    = cond_pass_reg;
  assign ovf_sticky_o   = sticky_reg;
  assign ovf_count_o    = count_reg;
  assign ovf_trap_req_o = (state_reg == ST_REQ);

endmodule
